// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: square wave or strobe output plus terminal tick.
// Divisor reloads go through a shadow register and take effect only on a period boundary.
module clk_div_prog #(
    parameter int unsigned    W         = 32,
    parameter logic [W-1:0]   D_DEFAULT = W'(25000000)
) (
    input  logic         cin,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync_clr,
    input  logic         mode,
    input  logic [W-1:0] div_in,
    input  logic         div_load,
    output logic         cout,
    output logic         tick,
    output logic         pend,
    output logic [W-1:0] div_act
);

    // A zero divisor is meaningless; store it as 1 everywhere it can land.
    localparam logic [W-1:0] D_RST = (D_DEFAULT == '0) ? W'(1) : D_DEFAULT;

    logic [W-1:0] count;
    logic [W-1:0] shadow;
    logic         mode_q;

    logic [W-1:0] ld_val_c;
    logic         restart_c;
    logic         term_c;

    assign ld_val_c  = (div_in == '0) ? W'(1) : div_in;
    // A mode change restarts the period exactly like sync_clr.
    assign restart_c = sync_clr | (mode ^ mode_q);
    // >= so a count stranded above a shrunken divisor wraps at once.
    assign term_c    = en & (count >= (div_act - W'(1)));

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            shadow  <= D_RST;
            div_act <= D_RST;
            mode_q  <= 1'b0;
            cout    <= 1'b0;
            tick    <= 1'b0;
            pend    <= 1'b0;
        end else begin
            mode_q <= mode;
            if (restart_c) begin
                count <= '0;
                cout  <= 1'b0;
                tick  <= 1'b0;
                if (div_load) begin
                    div_act <= ld_val_c;
                    pend    <= 1'b0;
                end else if (pend) begin
                    div_act <= shadow;
                    pend    <= 1'b0;
                end
            end else if (!en) begin
                // Frozen: no boundary to glitch, so a pending divisor applies now.
                tick <= 1'b0;
                if (div_load) begin
                    shadow <= ld_val_c;
                    pend   <= 1'b1;
                end else if (pend) begin
                    div_act <= shadow;
                    pend    <= 1'b0;
                end
            end else if (term_c) begin
                count <= '0;
                tick  <= 1'b1;
                cout  <= mode ? 1'b1 : ~cout;
                if (div_load) begin
                    div_act <= ld_val_c;
                    pend    <= 1'b0;
                end else if (pend) begin
                    div_act <= shadow;
                    pend    <= 1'b0;
                end
            end else begin
                count <= count + W'(1);
                tick  <= 1'b0;
                cout  <= mode ? 1'b0 : cout;
                if (div_load) begin
                    shadow <= ld_val_c;
                    pend   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios then random traffic,
// compared each cycle against a rule-level reference model.
module tb_clk_div_prog;

    localparam int unsigned W    = 16;
    localparam int          DDEF = 4;

    logic         cin = 1'b0;
    logic         rst_n;
    logic         en;
    logic         sync_clr;
    logic         mode;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         cout;
    logic         tick;
    logic         pend;
    logic [W-1:0] div_act;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_count;
    int m_act;
    int m_shadow;
    bit m_cout;
    bit m_tick;
    bit m_pend;
    bit m_modeq;

    clk_div_prog #(.W(W), .D_DEFAULT(W'(DDEF))) dut (
        .cin      (cin),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .mode     (mode),
        .div_in   (div_in),
        .div_load (div_load),
        .cout     (cout),
        .tick     (tick),
        .pend     (pend),
        .div_act  (div_act)
    );

    always #5 cin = ~cin;

    task automatic check1(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check1("cout",    W'(cout),    W'(m_cout));
        check1("tick",    W'(tick),    W'(m_tick));
        check1("pend",    W'(pend),    W'(m_pend));
        check1("div_act", div_act,     W'(m_act));
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_act    = DDEF;
        m_shadow = DDEF;
        m_cout   = 1'b0;
        m_tick   = 1'b0;
        m_pend   = 1'b0;
        m_modeq  = 1'b0;
    endtask

    // One clock of the rules: divisor bookkeeping, then counter/outputs.
    task automatic model_step();
        int ld;
        bit restart;
        bit term;
        ld      = (div_in == '0) ? 1 : int'(div_in);
        restart = sync_clr || (mode != m_modeq);
        term    = en && (m_count >= m_act - 1);

        if (div_load && (restart || term)) begin
            m_act  = ld;
            m_pend = 1'b0;
        end else if (div_load) begin
            m_shadow = ld;
            m_pend   = 1'b1;
        end else if (m_pend && (restart || !en || term)) begin
            m_act  = m_shadow;
            m_pend = 1'b0;
        end

        if (restart) begin
            m_count = 0;
            m_cout  = 1'b0;
            m_tick  = 1'b0;
        end else if (!en) begin
            m_tick = 1'b0;
        end else if (term) begin
            m_count = 0;
            m_tick  = 1'b1;
            m_cout  = mode ? 1'b1 : !m_cout;
        end else begin
            m_count = m_count + 1;
            m_tick  = 1'b0;
            if (mode) m_cout = 1'b0;
        end
        m_modeq = mode;
    endtask

    task automatic cycle();
        @(posedge cin);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_count(input int c);
        int g = 0;
        while (m_count != c && g < 64) begin
            cycle();
            g++;
        end
        vectors++;
        assert (g < 64) else begin
            miscompares++;
            $error("FAIL wait_count: observed timeout expected count %0d", c);
        end
    endtask

    task automatic wait_term();
        int g = 0;
        while (m_count < m_act - 1 && g < 64) begin
            cycle();
            g++;
        end
        vectors++;
        assert (g < 64) else begin
            miscompares++;
            $error("FAIL wait_term: observed timeout expected terminal count");
        end
    endtask

    task automatic load(input int v);
        div_in   = W'(v);
        div_load = 1'b1;
        cycle();
        div_load = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        sync_clr = 1'b0;
        mode     = 1'b0;
        div_in   = '0;
        div_load = 1'b0;
        model_reset();
        #12;
        check_all();
        cycle();
        rst_n = 1'b1;
        run(20);

        // Pulse mode, then divisor 1 gives constant-high strobe.
        mode = 1'b1;
        run(16);
        load(1);
        run(8);
        mode = 1'b0;
        load(4);
        run(10);

        // Reload mid-period, then zero divisor.
        wait_count(1);
        load(6);
        run(20);
        wait_count(2);
        load(0);
        run(8);
        load(4);
        run(6);

        // Two loads before the boundary; load on the exact terminal cycle.
        wait_count(1);
        div_in   = W'(5);
        div_load = 1'b1;
        cycle();
        div_in = W'(7);
        cycle();
        div_load = 1'b0;
        run(20);
        wait_term();
        load(3);
        run(10);

        // Freeze with a load during the freeze.
        wait_count(2);
        en = 1'b0;
        run(3);
        load(2);
        run(6);
        en = 1'b1;
        run(10);

        // sync_clr while cout is high at count 3.
        load(6);
        begin
            int g = 0;
            while (!(m_count == 3 && m_cout) && g < 64) begin
                cycle();
                g++;
            end
            vectors++;
            assert (g < 64) else begin
                miscompares++;
                $error("FAIL wait_clr_point: observed timeout expected count 3 with cout high");
            end
        end
        sync_clr = 1'b1;
        cycle();
        sync_clr = 1'b0;
        run(10);

        // Mode change mid-period.
        wait_count(2);
        mode = 1'b1;
        run(12);
        mode = 1'b0;
        run(4);

        // Asynchronous reset with a pending load.
        wait_count(1);
        load(9);
        async_reset();
        run(10);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom % 8) != 0;
            sync_clr = ($urandom % 40) == 0;
            if (($urandom % 60) == 0) mode = ~mode;
            div_load = ($urandom % 8) == 0;
            div_in   = W'($urandom_range(0, 9));
            if (($urandom % 500) == 0) begin
                div_load = 1'b0;
                async_reset();
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
